// File: rtl/pipe_hazard_ctrl.sv
// Hazard and sequencing control for the IF/ID and ID/EXE registers.
// Handles load-use stalls, taken branches, CSR drain/issue and trap entry, and counts bubbles.
module pipe_hazard_ctrl #(
  parameter int DRAIN_CYCLES = 3,
  parameter int CNT_W        = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             im_stall,
  input  logic             dm_stall,
  input  logic [4:0]       ID_rs1_addr,
  input  logic [4:0]       ID_rs2_addr,
  input  logic             ID_use_rs1,
  input  logic             ID_use_rs2,
  input  logic             ID_csr_op,
  input  logic             EXE_MemRead,
  input  logic [4:0]       EXE_write_addr,
  input  logic             EXE_branch_taken,
  input  logic             trap_req,
  output logic             pc_write,
  output logic             ifid_write,
  output logic             ifid_flush,
  output logic             Control_flush,
  output logic             CSR_stall,
  output logic             CSR_reset,
  output logic             pc_sel_trap,
  output logic [CNT_W-1:0] bubble_cnt
);
  localparam int DW = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;

  typedef enum logic [1:0] {RUN, DRAIN, ISSUE, TRAP} state_t;

  state_t           r_state, w_nxt_state;
  logic [DW-1:0]    r_drain_cnt, w_nxt_drain;
  logic [CNT_W-1:0] r_bubble_cnt;
  logic             w_freeze, w_load_use, w_bubble;

  assign w_freeze   = im_stall | dm_stall;
  assign w_load_use = EXE_MemRead && (EXE_write_addr != 5'd0) &&
                      ((ID_use_rs1 && (ID_rs1_addr == EXE_write_addr)) ||
                       (ID_use_rs2 && (ID_rs2_addr == EXE_write_addr)));

  always_comb begin
    w_nxt_state   = r_state;
    w_nxt_drain   = r_drain_cnt;
    pc_write      = 1'b0;
    ifid_write    = 1'b0;
    ifid_flush    = 1'b0;
    Control_flush = 1'b0;
    CSR_stall     = 1'b0;
    CSR_reset     = 1'b0;
    pc_sel_trap   = 1'b0;
    if (!reset) begin
      // Outputs follow reset immediately, independent of the other inputs.
      pc_write   = 1'b1;
      ifid_write = 1'b1;
    end else if (w_freeze) begin
      CSR_stall = (r_state == DRAIN);
    end else begin
      unique case (r_state)
        RUN, DRAIN, ISSUE: begin
          if (trap_req) begin
            w_nxt_state = TRAP;
            w_nxt_drain = '0;
            pc_write    = 1'b1;
            pc_sel_trap = 1'b1;
            ifid_flush  = 1'b1;
            CSR_reset   = 1'b1;
          end else if (r_state == DRAIN) begin
            CSR_stall = 1'b1;
            if (r_drain_cnt == DW'(DRAIN_CYCLES - 1)) begin
              w_nxt_state = ISSUE;
              w_nxt_drain = '0;
            end else begin
              w_nxt_drain = r_drain_cnt + 1'b1;
            end
          end else if (r_state == ISSUE) begin
            // The CSR op still sits in ID; let it go instead of re-draining.
            w_nxt_state = RUN;
            pc_write    = 1'b1;
            ifid_write  = 1'b1;
          end else if (EXE_branch_taken) begin
            pc_write      = 1'b1;
            ifid_write    = 1'b1;
            ifid_flush    = 1'b1;
            Control_flush = 1'b1;
          end else if (w_load_use) begin
            Control_flush = 1'b1;
          end else if (ID_csr_op) begin
            w_nxt_state = DRAIN;
            w_nxt_drain = '0;
            CSR_stall   = 1'b1;
          end else begin
            pc_write   = 1'b1;
            ifid_write = 1'b1;
          end
        end
        TRAP: begin
          w_nxt_state   = RUN;
          pc_write      = 1'b1;
          ifid_write    = 1'b1;
          ifid_flush    = 1'b1;
          Control_flush = 1'b1;
        end
        default: w_nxt_state = RUN;
      endcase
    end
  end

  assign w_bubble   = reset && !w_freeze && (Control_flush || CSR_stall || CSR_reset);
  assign bubble_cnt = r_bubble_cnt;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state      <= RUN;
      r_drain_cnt  <= '0;
      r_bubble_cnt <= '0;
    end else begin
      r_state     <= w_nxt_state;
      r_drain_cnt <= w_nxt_drain;
      if (w_bubble) r_bubble_cnt <= r_bubble_cnt + CNT_W'(1);
    end
  end
endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed bench for pipe_hazard_ctrl: driver queues expected outputs, negedge monitor checks them.
module tb_pipe_hazard_ctrl;
  logic        clk = 1'b0;
  logic        reset;
  logic        im_stall, dm_stall, ID_use_rs1, ID_use_rs2, ID_csr_op;
  logic        EXE_MemRead, EXE_branch_taken, trap_req;
  logic [4:0]  ID_rs1_addr, ID_rs2_addr, EXE_write_addr;
  logic        pc_write, ifid_write, ifid_flush, Control_flush, CSR_stall, CSR_reset, pc_sel_trap;
  logic [31:0] bubble_cnt;

  typedef struct {
    string       nm;
    logic [6:0]  o;
    logic [31:0] c;
  } exp_t;

  exp_t q[$];
  logic tb_vld = 1'b0;
  int   checks = 0;
  int   errors = 0;

  // {pc_write, ifid_write, ifid_flush, Control_flush, CSR_stall, CSR_reset, pc_sel_trap}
  localparam logic [6:0] NORM = 7'b1100000;
  localparam logic [6:0] LU   = 7'b0001000;
  localparam logic [6:0] STL  = 7'b0000100;
  localparam logic [6:0] BR   = 7'b1111000;
  localparam logic [6:0] TRE  = 7'b1010011;
  localparam logic [6:0] TRP  = 7'b1111000;
  localparam logic [6:0] FRZ  = 7'b0000000;

  pipe_hazard_ctrl #(.DRAIN_CYCLES(3), .CNT_W(32)) dut (
    .clk(clk), .reset(reset), .im_stall(im_stall), .dm_stall(dm_stall),
    .ID_rs1_addr(ID_rs1_addr), .ID_rs2_addr(ID_rs2_addr),
    .ID_use_rs1(ID_use_rs1), .ID_use_rs2(ID_use_rs2), .ID_csr_op(ID_csr_op),
    .EXE_MemRead(EXE_MemRead), .EXE_write_addr(EXE_write_addr),
    .EXE_branch_taken(EXE_branch_taken), .trap_req(trap_req),
    .pc_write(pc_write), .ifid_write(ifid_write), .ifid_flush(ifid_flush),
    .Control_flush(Control_flush), .CSR_stall(CSR_stall), .CSR_reset(CSR_reset),
    .pc_sel_trap(pc_sel_trap), .bubble_cnt(bubble_cnt)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (tb_vld) begin
      if (q.size() == 0) begin
        errors++;
        $display("FAIL scoreboard_empty: output presented with no expectation queued");
      end else begin
        exp_t e;
        e = q.pop_front();
        checks++;
        if ({pc_write, ifid_write, ifid_flush, Control_flush, CSR_stall, CSR_reset, pc_sel_trap} !== e.o) begin
          errors++;
          $display("FAIL %s outs: got %b expected %b", e.nm,
                   {pc_write, ifid_write, ifid_flush, Control_flush, CSR_stall, CSR_reset, pc_sel_trap}, e.o);
        end
        checks++;
        if (bubble_cnt !== e.c) begin
          errors++;
          $display("FAIL %s bubble_cnt: got %0d expected %0d", e.nm, bubble_cnt, e.c);
        end
      end
    end
  end

  task automatic step(input string nm, input logic rs, im, dm,
                      input logic [4:0] r1, r2, input logic u1, u2, cs, mr,
                      input logic [4:0] wa, input logic br, tr,
                      input logic [6:0] eo, input logic [31:0] ec);
    exp_t e;
    @(posedge clk);
    #1;
    reset = rs; im_stall = im; dm_stall = dm;
    ID_rs1_addr = r1; ID_rs2_addr = r2; ID_use_rs1 = u1; ID_use_rs2 = u2;
    ID_csr_op = cs; EXE_MemRead = mr; EXE_write_addr = wa;
    EXE_branch_taken = br; trap_req = tr;
    e.nm = nm; e.o = eo; e.c = ec;
    q.push_back(e);
    tb_vld = 1'b1;
  endtask

  task automatic idle(input string nm, input logic [6:0] eo, input logic [31:0] ec);
    step(nm, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, eo, ec);
  endtask

  task automatic csr(input string nm, input logic dm, input logic [6:0] eo, input logic [31:0] ec);
    step(nm, 1, 0, dm, 0, 0, 0, 0, 1, 0, 0, 0, 0, eo, ec);
  endtask

  initial begin
    reset = 0; im_stall = 0; dm_stall = 0; ID_rs1_addr = 0; ID_rs2_addr = 0;
    ID_use_rs1 = 0; ID_use_rs2 = 0; ID_csr_op = 0; EXE_MemRead = 0;
    EXE_write_addr = 0; EXE_branch_taken = 0; trap_req = 0;

    // reset held with busy inputs: reset values regardless
    step("rst_hold",   0, 0, 0, 5, 0, 1, 0, 1, 1, 5, 1, 1, NORM, 0);
    step("rst_hold2",  0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, NORM, 0);
    // T1 load-use on rs1, then on rs2, and a non-use
    step("t1_lu_rs1",  1, 0, 0, 5, 0, 1, 0, 0, 1, 5, 0, 0, LU,   0);
    idle("t1_after",   NORM, 1);
    step("lu_rs2",     1, 0, 0, 3, 7, 1, 1, 0, 1, 7, 0, 0, LU,   1);
    idle("lu_rs2_aft", NORM, 2);
    step("lu_nouse",   1, 0, 0, 5, 5, 0, 0, 0, 1, 5, 0, 0, NORM, 2);
    // T2 x0 never stalls; branch beats load-use
    step("t2_x0",      1, 0, 0, 0, 0, 1, 1, 0, 1, 0, 0, 0, NORM, 2);
    step("t2_br_lu",   1, 0, 0, 5, 0, 1, 0, 0, 1, 5, 1, 0, BR,   2);
    idle("t2_after",   NORM, 3);
    // T3 CSR drain: RUN + 3 DRAIN stall, ISSUE, RUN
    csr("t3_run",   0, STL,  3);
    csr("t3_d0",    0, STL,  4);
    csr("t3_d1",    0, STL,  5);
    csr("t3_d2",    0, STL,  6);
    csr("t3_issue", 0, NORM, 7);
    idle("t3_run2", NORM, 7);
    // T4 freeze in the middle of the drain
    csr("t4_run",   0, STL, 7);
    csr("t4_d0",    0, STL, 8);
    for (int i = 0; i < 5; i++) csr("t4_frz", 1, STL, 9);
    csr("t4_d1",    0, STL,  9);
    csr("t4_d2",    0, STL,  10);
    csr("t4_issue", 0, NORM, 11);
    idle("t4_run2", NORM, 11);
    // freeze in RUN masks trap and branch
    step("frz_run",    1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1, FRZ,  11);
    idle("frz_after",  NORM, 11);
    // T5 trap aborts the drain
    csr("t5_run",   0, STL, 11);
    csr("t5_d0",    0, STL, 12);
    step("t5_trap",    1, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 1, TRE,  13);
    idle("t5_trapst",  TRP,  14);
    idle("t5_run",     NORM, 15);
    // trap from RUN beats branch and load-use
    step("trap_run",   1, 0, 0, 5, 0, 1, 0, 0, 1, 5, 1, 1, TRE,  15);
    idle("trap_st",    TRP,  16);
    step("trap_run2",  1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, TRE,  17);
    // T6 reset asserted just after entering TRAP
    step("t6_rst",     0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, NORM, 0);
    step("t6_rst2",    0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, NORM, 0);
    idle("t6_run",     NORM, 0);
    // reset mid-DRAIN returns to RUN
    csr("rd_run",   0, STL, 0);
    step("rd_rst",     0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, NORM, 0);
    idle("rd_run2",    NORM, 0);

    @(posedge clk);
    #1;
    tb_vld = 1'b0;
    @(negedge clk);
    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: %0d expectations left, expected 0", q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
